// File: rtl/prio_enc8_ack_pkg.sv
// Shared definitions for the 8-to-3 acknowledged priority encoder.
//   state_t  : presentation FSM state (IDLE, HOLD)
//   N_REQ    : number of request lines
//   IDX_W    : width of the encoded index
//   A_L_IDLE : A_L value when no code is presented
package prio_enc8_ack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] A_L_IDLE = 3'b111;

endpackage

// File: rtl/prio_enc8_comb.sv
// Combinational highest-set-bit finder.
//   req : request vector, active-high, bit N_REQ-1 has highest priority
//   idx : index of the highest set bit (0 when none set)
//   any : at least one bit of req is set
module prio_enc8_comb
  import prio_enc8_ack_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/prio_enc8_ack.sv
// Registered 8-to-3 priority encoder with active-low requests and an
// acknowledge handshake. Request events are latched into a pending
// register; the highest pending line is presented and held until ACK.
//   clk     : system clock, rising edge
//   rst     : asynchronous reset, active-high
//   I_L     : request lines, active-low, asynchronous to clk
//   EI_L    : enable in, active-low
//   ACK     : consumer accepts the presented code
//   CLR_OVR : clears OVR
//   A_L     : presented index, active-low
//   GS_L    : group select, active-low, low while A_L is valid
//   EO_L    : enable out, active-low, low when enabled and idle/empty
//   OVR     : sticky overflow, a request hit an already pending line
//
// state | meaning
// IDLE  | nothing presented, waiting for a pending bit with EI_L low
// HOLD  | code on A_L held stable until ACK
module prio_enc8_ack
  import prio_enc8_ack_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] I_L,
  input  logic             EI_L,
  input  logic             ACK,
  input  logic             CLR_OVR,
  output logic [IDX_W-1:0] A_L,
  output logic             GS_L,
  output logic             EO_L,
  output logic             OVR
);

  logic [N_REQ-1:0] s1, s2;
  logic [N_REQ-1:0] pend, pend_next;
  logic [N_REQ-1:0] ev, set_vec, clr_vec;
  logic [IDX_W-1:0] top_idx;
  logic             top_any;
  logic             fire;
  logic             ovr_hit;
  state_t           state, state_next;

  prio_enc8_comb u_enc (
    .req (pend),
    .idx (top_idx),
    .any (top_any)
  );

  assign ev      = EDGE_MODE ? (s2 & ~s1) : ~s1;
  assign set_vec = ev & {N_REQ{~EI_L}};
  assign fire    = (state == HOLD) && ACK;

  // In HOLD, A_L carries the inverted index of the presented line.
  always_comb begin
    clr_vec = '0;
    if (fire) clr_vec[~A_L] = 1'b1;
  end

  // Set beats clear on the same bit.
  assign pend_next = (pend & ~clr_vec) | set_vec;

  // Level mode re-asserts the line every cycle, so the cycle that
  // consumes a bit must not count its own re-set as an overflow.
  assign ovr_hit = |(set_vec & pend & (EDGE_MODE ? {N_REQ{1'b1}} : ~clr_vec));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (top_any && !EI_L) state_next = HOLD;
      HOLD:    if (ACK) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= '1;
      s2    <= '1;
      pend  <= '0;
      state <= IDLE;
      A_L   <= A_L_IDLE;
      GS_L  <= 1'b1;
      EO_L  <= 1'b1;
      OVR   <= 1'b0;
    end else begin
      s1    <= I_L;
      s2    <= s1;
      pend  <= pend_next;
      state <= state_next;
      EO_L  <= ~(~EI_L && (pend_next == '0) && (state_next == IDLE));

      if (ovr_hit)      OVR <= 1'b1;
      else if (CLR_OVR) OVR <= 1'b0;

      case (state)
        IDLE: begin
          if (state_next == HOLD) begin
            A_L  <= ~top_idx;
            GS_L <= 1'b0;
          end
        end
        HOLD: begin
          if (ACK) begin
            A_L  <= A_L_IDLE;
            GS_L <= 1'b1;
          end
        end
        default: begin
          A_L  <= A_L_IDLE;
          GS_L <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_enc8_ack.sv
// Self-checking bench for prio_enc8_ack: directed scenarios followed by
// randomized traffic, all outputs compared every cycle against a
// request-queue style reference model.
module tb_prio_enc8_ack;

  localparam bit EDGE = 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] il;
  logic       ei;
  logic       ack;
  logic       clr_ovr;
  logic [2:0] a_l;
  logic       gs_l;
  logic       eo_l;
  logic       ovr;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit [7:0] m_s1, m_s2;
  bit       m_req [8];   // per-line pending request
  int       m_cur;       // presented line, -1 when none
  bit       m_eo;
  bit       m_ovr;

  prio_enc8_ack #(.EDGE_MODE(EDGE)) dut (
    .clk     (clk),
    .rst     (rst),
    .I_L     (il),
    .EI_L    (ei),
    .ACK     (ack),
    .CLR_OVR (clr_ovr),
    .A_L     (a_l),
    .GS_L    (gs_l),
    .EO_L    (eo_l),
    .OVR     (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit any_req();
    for (int i = 0; i < 8; i++) if (m_req[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] exp_a_l();
    if (m_cur < 0) return 3'b111;
    return 3'(7 - m_cur);
  endfunction

  task automatic model_reset();
    m_s1 = 8'hFF;
    m_s2 = 8'hFF;
    for (int i = 0; i < 8; i++) m_req[i] = 1'b0;
    m_cur = -1;
    m_eo  = 1'b1;
    m_ovr = 1'b0;
  endtask

  task automatic model_step();
    int  done;
    bit  hit;
    bit  had [8];
    bit  ev;
    done = (m_cur >= 0 && ack) ? m_cur : -1;
    hit  = 1'b0;
    for (int i = 0; i < 8; i++) had[i] = m_req[i];
    if (done >= 0) m_req[done] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ev = EDGE ? (m_s2[i] && !m_s1[i]) : !m_s1[i];
      if (ev && !ei) begin
        if (had[i] && (EDGE || i != done)) hit = 1'b1;
        m_req[i] = 1'b1;
      end
    end
    if (m_cur < 0) begin
      if (!ei) begin
        for (int i = 7; i >= 0; i--) begin
          if (had[i]) begin
            m_cur = i;
            break;
          end
        end
      end
    end else if (ack) begin
      m_cur = -1;
    end
    m_eo = !(!ei && !any_req() && m_cur < 0);
    if (hit) m_ovr = 1'b1;
    else if (clr_ovr) m_ovr = 1'b0;
    m_s2 = m_s1;
    m_s1 = il;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("a_l",  8'(a_l),  8'(exp_a_l()));
    check("gs_l", 8'(gs_l), 8'(m_cur < 0));
    check("eo_l", 8'(eo_l), 8'(m_eo));
    check("ovr",  8'(ovr),  8'(m_ovr));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int line);
    il = ~(8'h01 << line);
    tick();
    il = 8'hFF;
  endtask

  initial begin
    rst = 1'b1; il = 8'hFF; ei = 1'b0; ack = 1'b0; clr_ovr = 1'b0;
    model_reset();
    #11;
    check("rst_a_l", 8'(a_l), 8'h07);
    check("rst_gs",  8'(gs_l), 8'h01);
    check("rst_eo",  8'(eo_l), 8'h01);
    check("rst_ovr", 8'(ovr), 8'h00);
    #1 rst = 1'b0;
    tick();
    check("idle_eo", 8'(eo_l), 8'h00);

    // single request on line 5, held for 10 cycles
    pulse(5);
    ticks(2);
    check("req5_a_l", 8'(a_l), 8'h02);
    check("req5_gs",  8'(gs_l), 8'h00);
    ticks(10);
    check("req5_hold", 8'(a_l), 8'h02);
    ack = 1'b1; tick(); ack = 1'b0;
    check("req5_ack_gs", 8'(gs_l), 8'h01);
    check("req5_ack_eo", 8'(eo_l), 8'h00);

    // lines 2 and 6 together: 6 first, then 2 after a one-cycle gap
    il = ~8'h44; tick(); il = 8'hFF;
    ticks(2);
    check("prio_first", 8'(a_l), 8'h01);
    ack = 1'b1; tick(); ack = 1'b0;
    check("prio_gap", 8'(gs_l), 8'h01);
    tick();
    check("prio_second", 8'(a_l), 8'h05);
    ack = 1'b1; tick(); ack = 1'b0;
    check("prio_done", 8'(gs_l), 8'h01);

    // no pre-emption of line 1 by line 7
    pulse(1);
    ticks(2);
    check("npre_1", 8'(a_l), 8'h06);
    pulse(7);
    ticks(4);
    check("npre_hold", 8'(a_l), 8'h06);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    check("npre_7", 8'(a_l), 8'h00);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();

    // disabled: event on line 3 is ignored
    ei = 1'b1;
    pulse(3);
    ticks(3);
    check("dis_gs", 8'(gs_l), 8'h01);
    check("dis_eo", 8'(eo_l), 8'h01);
    ei = 1'b0;
    ticks(3);
    check("dis_after_gs", 8'(gs_l), 8'h01);

    // two events on line 4 before ACK -> overflow
    pulse(4);
    tick();
    pulse(4);
    tick();
    check("ovr_set", 8'(ovr), 8'h01);
    ack = 1'b1; tick(); ack = 1'b0;
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    check("ovr_clr", 8'(ovr), 8'h00);
    ticks(3);

    // async reset in the middle of HOLD
    pulse(0);
    tick();
    pulse(0);
    ticks(2);
    check("mid_hold", 8'(gs_l), 8'h00);
    #3 rst = 1'b1;
    #1;
    check("arst_a_l", 8'(a_l), 8'h07);
    check("arst_gs",  8'(gs_l), 8'h01);
    check("arst_ovr", 8'(ovr), 8'h00);
    model_reset();
    #2 rst = 1'b0;
    ticks(5);
    check("arst_quiet", 8'(gs_l), 8'h01);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) il[b] = ~il[b];
      ack     = ($urandom_range(0, 3) == 0);
      ei      = ($urandom_range(0, 15) == 0);
      clr_ovr = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
